// File: rtl/tuple_serializer.sv
// Tuple-to-stream converter: takes a (I0, I1) pair in one handshake and emits
// both elements in order (or swapped by S) on a single registered output lane.
module tuple_serializer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic             S,
  input  logic             I_valid,
  output logic             I_ready,
  output logic [WIDTH-1:0] O,
  output logic             O_valid,
  output logic             O_last,
  input  logic             O_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND0 = 2'd1,
    SEND1 = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_first;
  logic [WIDTH-1:0] r_second;
  logic [WIDTH-1:0] w_first_nxt;
  logic [WIDTH-1:0] w_second_nxt;
  logic [WIDTH-1:0] r_o;
  logic [WIDTH-1:0] w_o_nxt;
  logic             r_o_valid;
  logic             w_o_valid_nxt;
  logic             r_o_last;
  logic             w_o_last_nxt;
  logic             w_accept;
  logic             w_xfer;
  logic [WIDTH-1:0] w_load_first;
  logic [WIDTH-1:0] w_load_second;

  // Only O_ready reaches I_ready combinationally; data inputs never reach outputs.
  assign I_ready       = !RESET && ((r_state == IDLE) || ((r_state == SEND1) && O_ready));
  assign w_accept      = I_valid && I_ready;
  assign w_xfer        = r_o_valid && O_ready;
  assign w_load_first  = S ? I1 : I0;
  assign w_load_second = S ? I0 : I1;

  assign O       = r_o;
  assign O_valid = r_o_valid;
  assign O_last  = r_o_last;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= IDLE;
      r_first   <= '0;
      r_second  <= '0;
      r_o       <= '0;
      r_o_valid <= 1'b0;
      r_o_last  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_first   <= w_first_nxt;
      r_second  <= w_second_nxt;
      r_o       <= w_o_nxt;
      r_o_valid <= w_o_valid_nxt;
      r_o_last  <= w_o_last_nxt;
    end
  end

  // Next state and next registered outputs; everything holds while stalled.
  always_comb begin
    w_state_nxt   = r_state;
    w_first_nxt   = r_first;
    w_second_nxt  = r_second;
    w_o_nxt       = r_o;
    w_o_valid_nxt = r_o_valid;
    w_o_last_nxt  = r_o_last;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt   = SEND0;
          w_first_nxt   = w_load_first;
          w_second_nxt  = w_load_second;
          w_o_nxt       = w_load_first;
          w_o_valid_nxt = 1'b1;
          w_o_last_nxt  = 1'b0;
        end
      end
      SEND0: begin
        if (w_xfer) begin
          w_state_nxt  = SEND1;
          w_o_nxt      = r_second;
          w_o_last_nxt = 1'b1;
        end
      end
      SEND1: begin
        if (w_xfer && w_accept) begin
          w_state_nxt   = SEND0;
          w_first_nxt   = w_load_first;
          w_second_nxt  = w_load_second;
          w_o_nxt       = w_load_first;
          w_o_valid_nxt = 1'b1;
          w_o_last_nxt  = 1'b0;
        end else if (w_xfer) begin
          w_state_nxt   = IDLE;
          w_o_nxt       = '0;
          w_o_valid_nxt = 1'b0;
          w_o_last_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_o_nxt       = '0;
        w_o_valid_nxt = 1'b0;
        w_o_last_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_tuple_serializer.sv
// Bench for tuple_serializer: directed cycle tables plus randomized traffic
// checked against a queue-of-elements reference model.
module tb_tuple_serializer;

  localparam int unsigned WIDTH = 4;

  logic             CLK      = 1'b0;
  logic             r_reset  = 1'b1;
  logic             r_valid  = 1'b0;
  logic             r_s      = 1'b0;
  logic             r_oready = 1'b0;
  logic [WIDTH-1:0] r_i0     = '0;
  logic [WIDTH-1:0] r_i1     = '0;
  logic             w_i_ready;
  logic [WIDTH-1:0] w_o;
  logic             w_o_valid;
  logic             w_o_last;

  int checks = 0;
  int errors = 0;

  // Reference model: elements still owed to the consumer, oldest first.
  logic [WIDTH-1:0] q_d[$];
  logic             q_l[$];

  tuple_serializer #(.WIDTH(WIDTH)) dut (
    .CLK     (CLK),
    .RESET   (r_reset),
    .I0      (r_i0),
    .I1      (r_i1),
    .S       (r_s),
    .I_valid (r_valid),
    .I_ready (w_i_ready),
    .O       (w_o),
    .O_valid (w_o_valid),
    .O_last  (w_o_last),
    .O_ready (r_oready)
  );

  always #5 CLK = ~CLK;

  // A new tuple fits when nothing is owed, or only the last element is owed and leaves now.
  function automatic logic m_ready();
    return !r_reset && ((q_d.size() == 0) || ((q_d.size() == 1) && r_oready));
  endfunction

  always @(posedge CLK) begin
    if (r_reset) begin
      q_d.delete();
      q_l.delete();
    end else if (r_valid && m_ready()) begin
      if ((q_d.size() != 0) && r_oready) begin
        void'(q_d.pop_front());
        void'(q_l.pop_front());
      end
      q_d.push_back(r_s ? r_i1 : r_i0);
      q_l.push_back(1'b0);
      q_d.push_back(r_s ? r_i0 : r_i1);
      q_l.push_back(1'b1);
    end else if ((q_d.size() != 0) && r_oready) begin
      void'(q_d.pop_front());
      void'(q_l.pop_front());
    end
  end

  task automatic test_reset();
    r_reset  = 1'b1;
    r_valid  = 1'b1;
    r_oready = 1'b1;
    r_i0     = 4'h5;
    r_i1     = 4'h6;
    @(posedge CLK);
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      #1;
      checks++; if (w_i_ready !== 1'b0) begin errors++; $display("FAIL reset%0d I_ready got %b exp 0", k, w_i_ready); end
      checks++; if (w_o_valid !== 1'b0) begin errors++; $display("FAIL reset%0d O_valid got %b exp 0", k, w_o_valid); end
      checks++; if (w_o !== 4'h0) begin errors++; $display("FAIL reset%0d O got %h exp 0", k, w_o); end
      checks++; if (w_o_last !== 1'b0) begin errors++; $display("FAIL reset%0d O_last got %b exp 0", k, w_o_last); end
    end
    r_reset = 1'b0;
    r_valid = 1'b0;
    #1;
    checks++; if (w_i_ready !== 1'b1) begin errors++; $display("FAIL reset_release I_ready got %b exp 1", w_i_ready); end
    @(negedge CLK);
  endtask

  task automatic test_basic();
    bit [9:0]  vld  = 10'b1000000000;
    bit [9:0]  ordy = 10'b1111000000;
    bit [39:0] a    = 40'h3000000000;
    bit [39:0] b    = 40'hA000000000;
    bit [9:0]  er   = 10'b1011000000;
    bit [9:0]  ev   = 10'b0110000000;
    bit [9:0]  el   = 10'b0010000000;
    bit [39:0] eo   = 40'h03A0000000;
    for (int k = 0; k < 4; k++) begin
      int r;
      r = 9 - k;
      r_reset = 1'b0; r_valid = vld[r]; r_oready = ordy[r];
      if (vld[r]) begin r_i0 = a[r*4 +: 4]; r_i1 = b[r*4 +: 4]; r_s = 1'b0; end
      else begin r_i0 = WIDTH'($urandom); r_i1 = WIDTH'($urandom); r_s = 1'($urandom); end
      #1;
      checks++; if (w_i_ready !== er[r]) begin errors++; $display("FAIL basic row%0d I_ready got %b exp %b", k, w_i_ready, er[r]); end
      checks++; if (w_o_valid !== ev[r]) begin errors++; $display("FAIL basic row%0d O_valid got %b exp %b", k, w_o_valid, ev[r]); end
      checks++; if (w_o_last !== el[r]) begin errors++; $display("FAIL basic row%0d O_last got %b exp %b", k, w_o_last, el[r]); end
      if (ev[r]) begin checks++; if (w_o !== eo[r*4 +: 4]) begin errors++; $display("FAIL basic row%0d O got %h exp %h", k, w_o, eo[r*4 +: 4]); end end
      @(negedge CLK);
    end
  endtask

  task automatic test_swap();
    bit [9:0]  vld  = 10'b1000000000;
    bit [9:0]  ordy = 10'b1111000000;
    bit [39:0] a    = 40'h3000000000;
    bit [39:0] b    = 40'hA000000000;
    bit [9:0]  er   = 10'b1011000000;
    bit [9:0]  ev   = 10'b0110000000;
    bit [9:0]  el   = 10'b0010000000;
    bit [39:0] eo   = 40'h0A30000000;
    for (int k = 0; k < 4; k++) begin
      int r;
      r = 9 - k;
      r_reset = 1'b0; r_valid = vld[r]; r_oready = ordy[r];
      if (vld[r]) begin r_i0 = a[r*4 +: 4]; r_i1 = b[r*4 +: 4]; r_s = 1'b1; end
      else begin r_i0 = WIDTH'($urandom); r_i1 = WIDTH'($urandom); r_s = ~r_s; end
      #1;
      checks++; if (w_i_ready !== er[r]) begin errors++; $display("FAIL swap row%0d I_ready got %b exp %b", k, w_i_ready, er[r]); end
      checks++; if (w_o_valid !== ev[r]) begin errors++; $display("FAIL swap row%0d O_valid got %b exp %b", k, w_o_valid, ev[r]); end
      checks++; if (w_o_last !== el[r]) begin errors++; $display("FAIL swap row%0d O_last got %b exp %b", k, w_o_last, el[r]); end
      if (ev[r]) begin checks++; if (w_o !== eo[r*4 +: 4]) begin errors++; $display("FAIL swap row%0d O got %h exp %h", k, w_o, eo[r*4 +: 4]); end end
      @(negedge CLK);
    end
  endtask

  task automatic test_back_to_back();
    bit [9:0]  vld  = 10'b1111100000;
    bit [9:0]  ordy = 10'b1111111111;
    bit [39:0] a    = 40'h1335500000;
    bit [39:0] b    = 40'h2446600000;
    bit [9:0]  er   = 10'b1010101100;
    bit [9:0]  ev   = 10'b0111111000;
    bit [9:0]  el   = 10'b0010101000;
    bit [39:0] eo   = 40'h0123456000;
    for (int k = 0; k < 8; k++) begin
      int r;
      r = 9 - k;
      r_reset = 1'b0; r_valid = vld[r]; r_oready = ordy[r];
      if (vld[r]) begin r_i0 = a[r*4 +: 4]; r_i1 = b[r*4 +: 4]; r_s = 1'b0; end
      else begin r_i0 = WIDTH'($urandom); r_i1 = WIDTH'($urandom); r_s = 1'($urandom); end
      #1;
      checks++; if (w_i_ready !== er[r]) begin errors++; $display("FAIL b2b row%0d I_ready got %b exp %b", k, w_i_ready, er[r]); end
      checks++; if (w_o_valid !== ev[r]) begin errors++; $display("FAIL b2b row%0d O_valid got %b exp %b", k, w_o_valid, ev[r]); end
      checks++; if (w_o_last !== el[r]) begin errors++; $display("FAIL b2b row%0d O_last got %b exp %b", k, w_o_last, el[r]); end
      if (ev[r]) begin checks++; if (w_o !== eo[r*4 +: 4]) begin errors++; $display("FAIL b2b row%0d O got %h exp %h", k, w_o, eo[r*4 +: 4]); end end
      @(negedge CLK);
    end
  endtask

  task automatic test_backpressure();
    bit [9:0]  vld  = 10'b1111111000;
    bit [9:0]  ordy = 10'b1000100110;
    bit [39:0] a    = 40'h7FFFFFF000;
    bit [39:0] b    = 40'h8111111000;
    bit [9:0]  er   = 10'b1000000110;
    bit [9:0]  ev   = 10'b0111111100;
    bit [9:0]  el   = 10'b0000011100;
    bit [39:0] eo   = 40'h0777788800;
    for (int k = 0; k < 9; k++) begin
      int r;
      r = 9 - k;
      r_reset = 1'b0; r_valid = vld[r]; r_oready = ordy[r];
      if (vld[r]) begin r_i0 = a[r*4 +: 4]; r_i1 = b[r*4 +: 4]; r_s = 1'b0; end
      else begin r_i0 = WIDTH'($urandom); r_i1 = WIDTH'($urandom); r_s = 1'($urandom); end
      #1;
      checks++; if (w_i_ready !== er[r]) begin errors++; $display("FAIL bp row%0d I_ready got %b exp %b", k, w_i_ready, er[r]); end
      checks++; if (w_o_valid !== ev[r]) begin errors++; $display("FAIL bp row%0d O_valid got %b exp %b", k, w_o_valid, ev[r]); end
      checks++; if (w_o_last !== el[r]) begin errors++; $display("FAIL bp row%0d O_last got %b exp %b", k, w_o_last, el[r]); end
      if (ev[r]) begin checks++; if (w_o !== eo[r*4 +: 4]) begin errors++; $display("FAIL bp row%0d O got %h exp %h", k, w_o, eo[r*4 +: 4]); end end
      @(negedge CLK);
    end
  endtask

  task automatic test_mid_reset();
    bit [9:0]  rst  = 10'b0010000000;
    bit [9:0]  vld  = 10'b1001000000;
    bit [9:0]  ordy = 10'b1101111000;
    bit [39:0] a    = 40'h900D000000;
    bit [39:0] b    = 40'hC00E000000;
    bit [9:0]  er   = 10'b1001011000;
    bit [9:0]  ev   = 10'b0110110000;
    bit [9:0]  el   = 10'b0010010000;
    bit [9:0]  co   = 10'b0001000000;
    bit [39:0] eo   = 40'h09C0DE0000;
    for (int k = 0; k < 7; k++) begin
      int r;
      r = 9 - k;
      r_reset = rst[r]; r_valid = vld[r]; r_oready = ordy[r];
      if (vld[r]) begin r_i0 = a[r*4 +: 4]; r_i1 = b[r*4 +: 4]; r_s = 1'b0; end
      else begin r_i0 = WIDTH'($urandom); r_i1 = WIDTH'($urandom); r_s = 1'($urandom); end
      #1;
      checks++; if (w_i_ready !== er[r]) begin errors++; $display("FAIL midrst row%0d I_ready got %b exp %b", k, w_i_ready, er[r]); end
      checks++; if (w_o_valid !== ev[r]) begin errors++; $display("FAIL midrst row%0d O_valid got %b exp %b", k, w_o_valid, ev[r]); end
      checks++; if (w_o_last !== el[r]) begin errors++; $display("FAIL midrst row%0d O_last got %b exp %b", k, w_o_last, el[r]); end
      if (ev[r] || co[r]) begin checks++; if (w_o !== eo[r*4 +: 4]) begin errors++; $display("FAIL midrst row%0d O got %h exp %h", k, w_o, eo[r*4 +: 4]); end end
      @(negedge CLK);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 500; k++) begin
      r_reset  = ($urandom_range(0, 63) == 0);
      r_valid  = ($urandom_range(0, 3) != 0);
      r_oready = ($urandom_range(0, 3) != 0);
      r_i0     = WIDTH'($urandom);
      r_i1     = WIDTH'($urandom);
      r_s      = 1'($urandom);
      #1;
      checks++; if (w_i_ready !== m_ready()) begin errors++; $display("FAIL rand cyc%0d I_ready got %b exp %b", k, w_i_ready, m_ready()); end
      checks++; if (w_o_valid !== (q_d.size() != 0)) begin errors++; $display("FAIL rand cyc%0d O_valid got %b exp %b", k, w_o_valid, (q_d.size() != 0)); end
      if (q_d.size() != 0) begin
        checks++; if (w_o !== q_d[0]) begin errors++; $display("FAIL rand cyc%0d O got %h exp %h", k, w_o, q_d[0]); end
        checks++; if (w_o_last !== q_l[0]) begin errors++; $display("FAIL rand cyc%0d O_last got %b exp %b", k, w_o_last, q_l[0]); end
      end
      @(negedge CLK);
    end
    r_reset  = 1'b0;
    r_valid  = 1'b0;
    r_oready = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    checks++; if (w_o_valid !== 1'b0) begin errors++; $display("FAIL rand_drain O_valid got %b exp 0", w_o_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_swap();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
